// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a 16:1 bit mux: grants one requester at a time for up to HOLD cycles
// and captures the selected bit with its source tag. Optional MUX_SCHED_LOCK_EN adds a lock input.
module mux16_rr_sched #(
   parameter int unsigned HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic [15:0] in,
`ifdef MUX_SCHED_LOCK_EN
   input  logic        lock,
`endif
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        out,
   output logic        out_vld,
   output logic [3:0]  out_src
);

   localparam int unsigned N_SRC = 16;
   localparam int unsigned IDX_W = 4;
   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_GRANT = 1'b1;
   localparam logic [IDX_W-1:0] CNT_INIT = IDX_W'(HOLD - 1);

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [N_SRC-1:0] gnt_q, gnt_d;
   logic             out_q, out_d;
   logic             out_vld_q, out_vld_d;
   logic [IDX_W-1:0] out_src_q, out_src_d;

   logic [IDX_W-1:0] win_c;
   logic [IDX_W-1:0] idx_c;
   logic             hit_c;
   logic             req_any_c;
   logic             lock_hold_c;
   logic             issue_c;

   assign req_any_c = |req;

`ifdef MUX_SCHED_LOCK_EN
   assign lock_hold_c = lock & req[sel_q];
`else
   assign lock_hold_c = 1'b0;
`endif

   // First requester at or after ptr, wrapping 15 -> 0
   always_comb begin
      win_c = ptr_q;
      idx_c = ptr_q;
      hit_c = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         idx_c = ptr_q + IDX_W'(i);
         if (!hit_c && req[idx_c]) begin
            win_c = idx_c;
            hit_c = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         sel_q     <= '0;
         gnt_q     <= '0;
         out_q     <= 1'b0;
         out_vld_q <= 1'b0;
         out_src_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         gnt_q     <= gnt_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         out_src_q <= out_src_d;
      end
   end

   // Next-state, grant and capture logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      gnt_d     = gnt_q;
      out_d     = out_q;
      out_vld_d = 1'b0;
      out_src_d = out_src_q;
      issue_c   = 1'b0;

      if (gnt_q != '0) begin
         out_d     = in[sel_q];
         out_src_d = sel_q;
         out_vld_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_any_c) issue_c = 1'b1;
         end
         ST_GRANT: begin
            // Grant ends on expiry (unless locked) or on early release
            if (!req[sel_q] || ((cnt_q == '0) && !lock_hold_c)) begin
               if (req_any_c) begin
                  issue_c = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (!lock_hold_c) begin
               cnt_d = cnt_q - IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase

      if (issue_c) begin
         state_d = ST_GRANT;
         gnt_d   = N_SRC'(1) << win_c;
         sel_d   = win_c;
         cnt_d   = CNT_INIT;
         ptr_d   = win_c + IDX_W'(1);
      end
   end

   assign sel     = sel_q;
   assign gnt     = gnt_q;
   assign out     = out_q;
   assign out_vld = out_vld_q;
   assign out_src = out_src_q;

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares the 16-to-1 bit multiplexer among 16 requesters.
- Owns and drives the mux select; each granted source holds the mux for up to HOLD cycles.
- Captures the selected bit into a registered output tagged with its source index.
- Sits between the requesting sources and the single serial output path.

Parameters:
HOLD, 4, maximum consecutive grant cycles per source; legal range 1..15; 4-bit down-counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  16  request, one bit per source; level-sensitive
in  input  16  data bits, one per source; feeds the mux
sel  output  4  registered mux select; index of the current or last grantee
gnt  output  16  registered one-hot grant; all zero when idle
out  output  1  registered in[sel], captured in each cycle gnt is non-zero
out_vld  output  1  out holds a valid sample; gnt-active delayed by 1 cycle
out_src  output  4  source index of the current out sample

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - Outputs: sel=0, gnt=0, out=0, out_vld=0, out_src=0.
  - Internal: state=IDLE, ptr=0, cnt=0.
  - Reset overrides any in-progress grant.
- Arbitration function:
  - Search req starting at ptr, incrementing mod 16 (15 wraps to 0).
  - The first set bit wins, giving index w.
  - Whenever a grant is issued: ptr <= w+1 mod 16, so the previous winner is searched last.
- State IDLE (gnt=0):
  - If req != 0: the next edge issues a grant. gnt <= 1<<w, sel <= w, cnt <= HOLD-1, go to GRANT.
  - Otherwise stay in IDLE; sel keeps its last value.
- State GRANT (gnt=1<<sel):
  - The grant ends at the edge where cnt==0 or req[sel]==0 (early release).
  - Otherwise cnt decrements.
- At grant end:
  - If req != 0, the next grant is issued at the same edge (back-to-back, no idle bubble). The search uses the updated ptr, so a sole remaining requester is re-granted immediately.
  - If req == 0, go to IDLE with gnt=0.
- Capture:
  - Every cycle with gnt != 0: out <= in[sel], out_src <= sel, out_vld <= 1.
  - Otherwise out_vld <= 0; out and out_src hold.
- Latency:
  - req seen in IDLE at edge N -> gnt/sel valid after edge N+1 -> out_vld after edge N+2.
  - One out sample per grant cycle.
- Simultaneous events:
  - req rises for a new source while another is granted: no preemption; the new source waits for its turn.
  - req[sel] drops in the cycle cnt==0: treated as a single grant end.
  - The bit sampled in the last grant cycle is still captured.
- in changing mid-grant: each cycle's sample reflects in[sel] at that edge; no holding of data.
- Invariants: gnt is zero or one-hot; gnt != 0 implies gnt[sel]==1.

Optional Feature:
MUX_SCHED_LOCK_EN
- Defined:
  - Adds port: lock  input  1.
  - While lock=1 and req[sel]=1 in GRANT, cnt does not decrement and does not expire; the grant is extended indefinitely.
  - Early release on req[sel]=0 still applies.
  - lock is ignored in IDLE.
- Undefined: the port is absent; behaviour is identical to lock=0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=16'hFFFF -> sel=0, gnt=0, out=0, out_vld=0, out_src=0; first grant after release is gnt=16'h0001.
- Single requester: req=16'h0008, in=16'h30ab -> 1 cycle later gnt=16'h0008, sel=3; 1 cycle after that out=1, out_vld=1, out_src=3; the grant is re-issued at HOLD expiry with no bubble, so gnt stays 0008 continuously.
- Round-robin: req=16'h1005, in=16'h30ab, HOLD=4 -> grants 0,2,12,0 for 4 cycles each, no gaps; out sequence 4×1, 4×0, 4×1.
- Early release: source 5 granted, req[5] cleared during its 2nd grant cycle -> 2 cycles of gnt[5] and 2 out_vld samples with out_src=5; the next requester is granted at the following edge.
- Wrap-around: last grant to 15, req=16'h8001 -> next grant 0, then 15.
- Reset mid-grant and lock:
  - rst asserted during gnt=16'h0020 -> next cycle all outputs zero, ptr=0.
  - With MUX_SCHED_LOCK_EN, lock=1 and req=16'h0003 -> source 0 holds for 10+ cycles; source 1 is granted 1 edge after lock drops and cnt expires.
